fetch_decode_queue: RTL and testbench
=====================================

Name: fetch_decode_queue

Overview:
- Parametrised instruction queue between fetch and decode; replaces the fixed FETCH_WIDTH lane bundle handed directly to decode.
- Accepts up to FETCH_WIDTH instructions per cycle, compacting sparse lane-valids, and delivers up to DECODE_WIDTH instructions per cycle in program order.
- Predecodes a control-flow flag per entry, supports pipeline flush, and decouples fetch and decode widths.

Parameters:
FETCH_WIDTH, 2, instruction lanes accepted per cycle (1..4)
DECODE_WIDTH, 2, instruction lanes presented per cycle (1..4)
DEPTH, 8, queue entries; power of two, >= FETCH_WIDTH + DECODE_WIDTH
PC_WIDTH, 64, PC bits per entry

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush  in  1  discard all entries and this cycle's input
in_valid  in  FETCH_WIDTH  per-lane valid; any pattern allowed
in_instr  in  FETCH_WIDTH x 32  raw instruction words
in_pc  in  FETCH_WIDTH x PC_WIDTH  lane PCs
in_ready  out  1  queue can take a full FETCH_WIDTH group this cycle
out_valid  out  DECODE_WIDTH  lane i valid iff count > i (contiguous prefix)
out_instr  out  DECODE_WIDTH x 32  head entries, oldest in lane 0
out_pc  out  DECODE_WIDTH x PC_WIDTH  head PCs
out_is_ctrl  out  DECODE_WIDTH  opcode is OP_JAL, OP_JALR or OP_B
out_accept  in  clog2(DECODE_WIDTH+1)  number of head lanes consumed this cycle
count  out  clog2(DEPTH+1)  current occupancy

Behaviour:
- Clock and reset: single clock clk. resetn is asynchronous, active-low: clears head/tail pointers and count to 0, so out_valid = 0 and in_ready = 1. Entry storage is not reset.
- Storage: circular buffer with head and tail pointers of clog2(DEPTH) bits, wrapping modulo DEPTH naturally. count is held separately so a full queue and an empty queue are distinguishable.
- in_ready = (DEPTH - count) >= FETCH_WIDTH.
  - Computed from the registered count only; no combinational path from out_accept or in_valid.
  - The group is accepted all-or-nothing.
- Enqueue occurs when in_ready, any in_valid bit is set, and no flush:
  - Valid lanes are compacted in ascending lane order into entries tail, tail+1, and so on.
  - n_in = popcount(in_valid).
  - When in_ready = 0, input is ignored; fetch must hold it.
- Output is combinational from storage, with zero-cycle latency from head:
  - Lane i shows entry (head+i) mod DEPTH.
  - Data on lanes with out_valid = 0 is don't-care.
- Dequeue: n_out = min(out_accept, count, DECODE_WIDTH). An over-accept is clamped. The assertion module flags out_accept > popcount(out_valid).
- Simultaneous enqueue and dequeue in the same cycle:
  - count' = count + n_in - n_out
  - head' = head + n_out
  - tail' = tail + n_in
- Enqueue-to-output latency is 1 cycle: an entry written at edge N is visible on out_* after edge N.
- flush has priority over every other event that cycle:
  - head = tail = count = 0.
  - This cycle's enqueue is dropped and out_accept is ignored.
- out_is_ctrl is computed combinationally from bits [6:0] of each presented instruction.
- Boundary conditions:
  - Full: count = DEPTH, so in_ready = 0.
  - Exactly FETCH_WIDTH free: in_ready = 1.
  - Empty: all out_valid = 0, and out_accept is treated as 0.
  - Wrap-around: compaction and read indexing are both taken modulo DEPTH.
- Reset asserted mid-operation clears the queue immediately, regardless of clk.

Decomposition:
- The shared decode package gains:
  - parameters DECODE_WIDTH and FQ_DEPTH;
  - typedef fq_entry_t {u32 instr; u64 pc};
  - function is_ctrl_op(op_t), reusing the existing OP_JAL, OP_JALR and OP_B constants.
- One sub-module, fq_compact: combinational prefix-sum lane compactor that maps FETCH_WIDTH sparse lanes to dense write slots and reports n_in. It is reused by the later rename queue.

Test Plan:
1. Reset then idle: after resetn rises, count=0, out_valid=2'b00, in_ready=1.
2. Sparse enqueue: in_valid=2'b10, in_instr[1]=0x0000006F (jal), in_pc[1]=0x80000004, out_accept=0 -> next cycle out_valid=2'b01, out_pc[0]=0x80000004, out_is_ctrl[0]=1, count=1.
3. Fill to full (DEPTH=8, FW=2, no accept): four full groups -> count=8, in_ready=0; a fifth group is held off and count stays 8.
4. Simultaneous enqueue/dequeue with wrap: head=6, count=4, enqueue 2 lanes and out_accept=2 -> count=4, head=0, new entries land at slots 2 and 3; PC order is preserved.
5. Flush priority: count=5, flush=1 together with in_valid=2'b11 and out_accept=2 -> next cycle count=0, out_valid=0, in_ready=1.
6. Over-accept clamp: count=1, out_accept=2 -> count=0 next cycle, no underflow, and the assertion fires.

Source files
------------

// File: rtl/fetch_decode_queue_pkg.sv
// Shared decode package: queue sizing defaults, the queue entry type and
// the control-flow opcode predecode helper.
package fetch_decode_queue_pkg;

  localparam int unsigned FETCH_WIDTH  = 2;
  localparam int unsigned DECODE_WIDTH = 2;
  localparam int unsigned FQ_DEPTH     = 8;

  typedef logic [6:0] op_t;

  localparam op_t OP_JAL  = 7'b1101111;
  localparam op_t OP_JALR = 7'b1100111;
  localparam op_t OP_B    = 7'b1100011;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } fq_entry_t;

  function automatic logic is_ctrl_op(input op_t op);
    logic r;
    r = 1'b0;
    case (op)
      OP_JAL, OP_JALR, OP_B: r = 1'b1;
      default:               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fq_checker.sv
// Protocol monitor for the fetch/decode queue: raises a registered flag the
// cycle after decode accepts more lanes than were presented valid.
module fq_checker #(
  parameter  int unsigned DECODE_WIDTH = 2,
  localparam int unsigned AW           = $clog2(DECODE_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DECODE_WIDTH-1:0] out_valid,
  input  logic [AW-1:0]           out_accept,
  output logic                    over_accept_o
);

  logic [AW-1:0] pop_s;
  logic          over_accept_q;

  // number of presented valid lanes
  always_comb begin
    pop_s = '0;
    for (int i = 0; i < int'(DECODE_WIDTH); i++) begin
      pop_s = pop_s + AW'(out_valid[i]);
    end
  end

  // over-accept flag register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      over_accept_q <= 1'b0;
    end else begin
      over_accept_q <= (out_accept > pop_s);
    end
  end

  assign over_accept_o = over_accept_q;

endmodule

// File: rtl/fq_compact.sv
// Prefix-sum lane compactor: maps sparse valid lanes to dense slot offsets
// (ascending lane order) and reports how many lanes are valid.
module fq_compact #(
  parameter  int unsigned LANES = 2,
  localparam int unsigned CW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]         valid_i,
  output logic [LANES-1:0][CW-1:0] slot_o,
  output logic [CW-1:0]            n_o
);

  // running count of valid lanes below each lane gives its dense offset
  always_comb begin
    logic [CW-1:0] acc;
    acc    = '0;
    slot_o = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      slot_o[l] = acc;
      acc       = acc + CW'(valid_i[l]);
    end
    n_o = acc;
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// Circular instruction queue between fetch and decode: compacts sparse fetch
// lanes on enqueue and presents the oldest entries to decode in program order.
module fetch_decode_queue #(
  parameter  int unsigned FETCH_WIDTH  = fetch_decode_queue_pkg::FETCH_WIDTH,
  parameter  int unsigned DECODE_WIDTH = fetch_decode_queue_pkg::DECODE_WIDTH,
  parameter  int unsigned DEPTH        = fetch_decode_queue_pkg::FQ_DEPTH,
  parameter  int unsigned PC_WIDTH     = 64,
  localparam int unsigned AW           = $clog2(DECODE_WIDTH + 1),
  localparam int unsigned CNTW         = $clog2(DEPTH + 1)
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   flush,
  input  logic [FETCH_WIDTH-1:0]                 in_valid,
  input  logic [FETCH_WIDTH-1:0][31:0]           in_instr,
  input  logic [FETCH_WIDTH-1:0][PC_WIDTH-1:0]   in_pc,
  output logic                                   in_ready,
  output logic [DECODE_WIDTH-1:0]                out_valid,
  output logic [DECODE_WIDTH-1:0][31:0]          out_instr,
  output logic [DECODE_WIDTH-1:0][PC_WIDTH-1:0]  out_pc,
  output logic [DECODE_WIDTH-1:0]                out_is_ctrl,
  input  logic [AW-1:0]                          out_accept,
  output logic [CNTW-1:0]                        count
);

  import fetch_decode_queue_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(FETCH_WIDTH + 1);

  fq_entry_t mem_q [DEPTH];

  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;

  logic [FETCH_WIDTH-1:0][CW-1:0] slot_s;
  logic [FETCH_WIDTH-1:0][PW-1:0] wr_idx_s;
  logic [CW-1:0]                  n_in_s;
  logic [AW-1:0]                  n_out_s;
  logic                           enq_s;

  fq_compact #(.LANES(FETCH_WIDTH)) u_compact (
    .valid_i (in_valid),
    .slot_o  (slot_s),
    .n_o     (n_in_s)
  );

  assign in_ready = (DEPTH - 32'(count_q)) >= FETCH_WIDTH;
  assign enq_s    = in_ready & (|in_valid) & ~flush;
  assign count    = count_q;

  // write slots wrap modulo DEPTH through the pointer width
  always_comb begin
    wr_idx_s = '0;
    for (int l = 0; l < int'(FETCH_WIDTH); l++) begin
      wr_idx_s[l] = tail_q + PW'(slot_s[l]);
    end
  end

  // entry storage; deliberately not reset
  always_ff @(posedge clk) begin
    if (enq_s) begin
      for (int l = 0; l < int'(FETCH_WIDTH); l++) begin
        if (in_valid[l]) begin
          mem_q[wr_idx_s[l]] <= '{instr: in_instr[l], pc: 64'(in_pc[l])};
        end
      end
    end
  end

  // head-relative read lanes with control-flow predecode
  always_comb begin
    logic [PW-1:0] rd_idx;
    rd_idx      = '0;
    out_valid   = '0;
    out_instr   = '0;
    out_pc      = '0;
    out_is_ctrl = '0;
    for (int i = 0; i < int'(DECODE_WIDTH); i++) begin
      rd_idx         = head_q + PW'(i);
      out_valid[i]   = 32'(count_q) > 32'(i);
      out_instr[i]   = mem_q[rd_idx].instr;
      out_pc[i]      = mem_q[rd_idx].pc[PC_WIDTH-1:0];
      out_is_ctrl[i] = is_ctrl_op(mem_q[rd_idx].instr[6:0]);
    end
  end

  // over-accepts are clamped to what is actually presented
  always_comb begin
    int unsigned lim;
    lim = (32'(count_q) < DECODE_WIDTH) ? 32'(count_q) : DECODE_WIDTH;
    if (32'(out_accept) < lim) begin
      n_out_s = out_accept;
    end else begin
      n_out_s = AW'(lim);
    end
  end

  // pointer/occupancy next state; flush overrides enqueue and dequeue
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(n_out_s);
      if (enq_s) begin
        tail_d  = tail_q + PW'(n_in_s);
        count_d = count_q + CNTW'(n_in_s) - CNTW'(n_out_s);
      end else begin
        tail_d  = tail_q;
        count_d = count_q - CNTW'(n_out_s);
      end
    end
  end

  // pointer/occupancy registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: directed scenarios with literal
// expectations followed by randomized traffic against a queue-based model.
module tb_fetch_decode_queue;

  localparam int FW    = 2;
  localparam int DW    = 2;
  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  logic                clk;
  logic                resetn;
  logic                flush;
  logic [FW-1:0]       in_valid;
  logic [FW-1:0][31:0] in_instr;
  logic [FW-1:0][63:0] in_pc;
  logic                in_ready;
  logic [DW-1:0]       out_valid;
  logic [DW-1:0][31:0] out_instr;
  logic [DW-1:0][63:0] out_pc;
  logic [DW-1:0]       out_is_ctrl;
  logic [1:0]          out_accept;
  logic [3:0]          count;
  logic                over_flag;

  ent_t mq[$];
  bit   flag_exp;
  bit   chk_en;
  int   errs;
  int   checks;
  logic [6:0] op_tab [6] = '{7'h6F, 7'h67, 7'h63, 7'h33, 7'h13, 7'h03};

  fetch_decode_queue #(
    .FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH), .PC_WIDTH(64)
  ) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_is_ctrl(out_is_ctrl), .out_accept(out_accept), .count(count)
  );

  fq_checker #(.DECODE_WIDTH(DW)) chk_u (
    .clk(clk), .resetn(resetn), .out_valid(out_valid),
    .out_accept(out_accept), .over_accept_o(over_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_ctrl(input logic [31:0] w);
    return (w[6:0] == 7'h6F) || (w[6:0] == 7'h67) || (w[6:0] == 7'h63);
  endfunction

  // reference queue behaviour at a rising edge, from the pre-edge inputs
  task automatic model_step();
    int sz, lim, nout;
    bit rdy;
    ent_t e;
    if (!resetn) begin
      mq.delete();
      flag_exp = 1'b0;
      return;
    end
    sz       = mq.size();
    lim      = (sz < DW) ? sz : DW;
    flag_exp = (int'(out_accept) > lim);
    rdy      = (DEPTH - sz) >= FW;
    if (flush) begin
      mq.delete();
      return;
    end
    nout = (int'(out_accept) < lim) ? int'(out_accept) : lim;
    repeat (nout) void'(mq.pop_front());
    if (rdy) begin
      for (int l = 0; l < FW; l++) begin
        if (in_valid[l]) begin
          e.instr = in_instr[l];
          e.pc    = in_pc[l];
          mq.push_back(e);
        end
      end
    end
  endtask

  // compare DUT against the model every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 64'(count), 64'(mq.size()));
      chk("in_ready", 64'(in_ready), 64'((DEPTH - mq.size()) >= FW));
      chk("over_flag", 64'(over_flag), 64'(flag_exp));
      for (int i = 0; i < DW; i++) begin
        chk("out_valid", 64'(out_valid[i]), 64'(i < mq.size()));
        if (i < mq.size()) begin
          chk("out_instr", 64'(out_instr[i]), 64'(mq[i].instr));
          chk("out_pc", out_pc[i], mq[i].pc);
          chk("out_is_ctrl", 64'(out_is_ctrl[i]), 64'(exp_ctrl(mq[i].instr)));
        end
      end
    end
  end

  task automatic cyc(input logic [1:0] v, input logic [1:0] acc, input logic fl);
    in_valid   = v;
    out_accept = acc;
    flush      = fl;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [31:0] w, input logic [63:0] pc);
    in_instr[l] = w;
    in_pc[l]    = pc;
  endtask

  task automatic reset_pulse();
    resetn = 1'b0;
    mq.delete();
    flag_exp = 1'b0;
    cyc(2'b00, 2'd0, 1'b0);
    resetn = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    logic [1:0]  v, acc;
    errs = 0; checks = 0; chk_en = 0; flag_exp = 0;
    resetn = 1'b0; flush = 1'b0; in_valid = '0; in_instr = '0; in_pc = '0; out_accept = '0;
    repeat (2) @(negedge clk);
    #1;
    resetn = 1'b1;
    chk_en = 1;

    // reset then idle
    cyc(2'b00, 2'd0, 1'b0);
    chk("t1_count", 64'(count), 64'd0);
    chk("t1_out_valid", 64'(out_valid), 64'd0);
    chk("t1_in_ready", 64'(in_ready), 64'd1);

    // sparse enqueue on lane 1 only
    set_lane(0, 32'h00000013, 64'hDEAD);
    set_lane(1, 32'h0000006F, 64'h80000004);
    cyc(2'b10, 2'd0, 1'b0);
    chk("t2_out_valid", 64'(out_valid), 64'b01);
    chk("t2_out_pc0", out_pc[0], 64'h80000004);
    chk("t2_is_ctrl0", 64'(out_is_ctrl[0]), 64'd1);
    chk("t2_count", 64'(count), 64'd1);
    cyc(2'b00, 2'd0, 1'b1);

    // fill to full; fifth group held off
    for (int k = 0; k < 4; k++) begin
      set_lane(0, 32'h00000013, 64'h1000 + 64'(8 * k));
      set_lane(1, 32'h00000033, 64'h1004 + 64'(8 * k));
      cyc(2'b11, 2'd0, 1'b0);
    end
    chk("t3_count", 64'(count), 64'd8);
    chk("t3_in_ready", 64'(in_ready), 64'd0);
    set_lane(0, 32'h00000013, 64'h2000);
    set_lane(1, 32'h00000013, 64'h2004);
    cyc(2'b11, 2'd0, 1'b0);
    chk("t3_held_count", 64'(count), 64'd8);
    chk("t3_held_pc0", out_pc[0], 64'h1000);

    // move head to 6 with count 4, then enqueue+dequeue across the wrap
    repeat (3) cyc(2'b00, 2'd2, 1'b0);
    chk("t4_pre_count", 64'(count), 64'd2);
    chk("t4_pre_pc0", out_pc[0], 64'h1018);
    set_lane(0, 32'h00000063, 64'h1020);
    set_lane(1, 32'h00000067, 64'h1024);
    cyc(2'b11, 2'd0, 1'b0);
    set_lane(0, 32'h00000013, 64'h1028);
    set_lane(1, 32'h00000013, 64'h102C);
    cyc(2'b11, 2'd2, 1'b0);
    chk("t4_count", 64'(count), 64'd4);
    chk("t4_pc0", out_pc[0], 64'h1020);
    chk("t4_pc1", out_pc[1], 64'h1024);
    chk("t4_ctrl", 64'(out_is_ctrl), 64'b11);

    // flush beats enqueue and dequeue
    set_lane(0, 32'h00000013, 64'h1030);
    cyc(2'b01, 2'd0, 1'b0);
    chk("t5_pre_count", 64'(count), 64'd5);
    cyc(2'b11, 2'd2, 1'b1);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_in_ready", 64'(in_ready), 64'd1);

    // over-accept is clamped and flagged
    set_lane(0, 32'h00000013, 64'h3000);
    cyc(2'b01, 2'd0, 1'b0);
    chk("t6_pre_count", 64'(count), 64'd1);
    cyc(2'b00, 2'd2, 1'b0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_flag", 64'(over_flag), 64'd1);

    // randomized traffic with occasional flush and mid-run reset
    for (int c = 0; c < 2000; c++) begin
      for (int l = 0; l < FW; l++) begin
        w      = $urandom;
        w[6:0] = op_tab[$urandom_range(0, 5)];
        set_lane(l, w, {$urandom, $urandom});
      end
      v   = 2'($urandom_range(0, 3));
      acc = ((c / 64) % 2 == 1) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      if ($urandom_range(0, 249) == 0) begin
        reset_pulse();
      end else begin
        cyc(v, acc, ($urandom_range(0, 39) == 0));
      end
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
